// File: rtl/cnn_run_ctrl.sv
// Inference run sequencer for cnn_core: start-pulse generation, result latching and run counting.
// Optional watchdog abort is compiled in when CNN_RUN_CTRL_TIMEOUT_EN is defined.
module cnn_run_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    output logic             cnn_start,
    input  logic             cnn_done,
    input  logic [3:0]       cnn_digit,
    output logic             busy,
    output logic             result_valid,
    output logic [3:0]       result_digit,
    output logic             timeout_err,
    output logic [CNT_W-1:0] run_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t state, state_nxt;
    logic   req_q;
    logic   accept;
    logic   wd_expire;

    assign accept = req & ~req_q;

`ifdef CNN_RUN_CTRL_TIMEOUT_EN
    localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYCLES - 1);
    logic [23:0] wd_cnt;

    // done takes priority over the terminal count, so expiry is qualified by ~cnn_done
    assign wd_expire = (wd_cnt == WD_LAST) & ~cnn_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (state == S_START) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT && !cnn_done) begin
            wd_cnt <= wd_cnt + 24'd1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (cnn_done || wd_expire) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cnn_start = 1'b0;
        busy      = 1'b0;
        case (state)
            S_START: begin
                cnn_start = 1'b1;
                busy      = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q        <= 1'b0;
            result_valid <= 1'b0;
            result_digit <= 4'h0;
            timeout_err  <= 1'b0;
            run_count    <= '0;
        end else begin
            req_q <= req;
            if (state == S_IDLE && accept) begin
                result_valid <= 1'b0;
                timeout_err  <= 1'b0;
            end else if (state == S_WAIT && cnn_done) begin
                result_digit <= cnn_digit;
                result_valid <= 1'b1;
                run_count    <= run_count + 1'b1;
            end else if (state == S_WAIT && wd_expire) begin
                timeout_err  <= 1'b1;
            end
        end
    end

endmodule
